// File: rtl/fdiv_float_pkg.sv
// rtl/fdiv_float_pkg.sv - shared state type, widths and flag indices for the iterative float divider
package fdiv_float_pkg;
   typedef enum logic [1:0] {IDLE, DIV, NORM, OUT} state_t;

   localparam int          BIAS    = 127;
   localparam int          QBITS   = 26;
   localparam int          EXP_W   = 10;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   localparam int FLAGS_W        = 5;
   localparam int FLAG_INVALID   = 4;
   localparam int FLAG_DIVBYZERO = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;
endpackage

// File: rtl/fdiv_float_if.sv
// rtl/fdiv_float_if.sv - operand/result stream bundle; oFLAGS exists only with FDIV_FLOAT_STATUS_EN
interface fdiv_float_if;
   logic        iDATA_REQ;
   logic        oDATA_BUSY;
   logic [31:0] iDATA_A;
   logic [31:0] iDATA_B;
   logic        oDATA_VALID;
   logic        iDATA_BUSY;
   logic [31:0] oDATA;
`ifdef FDIV_FLOAT_STATUS_EN
   logic [4:0]  oFLAGS;

   modport slave  (input  iDATA_REQ, iDATA_A, iDATA_B, iDATA_BUSY,
                   output oDATA_BUSY, oDATA_VALID, oDATA, oFLAGS);
   modport master (output iDATA_REQ, iDATA_A, iDATA_B, iDATA_BUSY,
                   input  oDATA_BUSY, oDATA_VALID, oDATA, oFLAGS);
`else
   modport slave  (input  iDATA_REQ, iDATA_A, iDATA_B, iDATA_BUSY,
                   output oDATA_BUSY, oDATA_VALID, oDATA);
   modport master (output iDATA_REQ, iDATA_A, iDATA_B, iDATA_BUSY,
                   input  oDATA_BUSY, oDATA_VALID, oDATA);
`endif
endinterface

// File: rtl/fdiv_float_norm_round.sv
// rtl/fdiv_float_norm_round.sv - normalize, round-to-nearest-even and pack a raw quotient (flags with FDIV_FLOAT_STATUS_EN)
module fdiv_float_norm_round
   import fdiv_float_pkg::*;
(
   input  logic                    sign,
   input  logic [QBITS-1:0]        q,
   input  logic                    sticky,
   input  logic signed [EXP_W-1:0] exp_in,
   output logic [31:0]             result
`ifdef FDIV_FLOAT_STATUS_EN
   ,
   output logic [FLAGS_W-1:0]      flags
`endif
);
   logic [22:0]             frac;
   logic [22:0]             frac_r;
   logic                    guard;
   logic                    stk;
   logic                    carry;
   logic signed [EXP_W-1:0] exp_n;
   logic signed [EXP_W-1:0] exp_r;

   always_comb begin
      // Hidden bit is q[25] or q[24]; only the fraction below it is rounded.
      if (q[QBITS-1]) begin
         frac  = q[24:2];
         guard = q[1];
         stk   = sticky | q[0];
         exp_n = exp_in;
      end else begin
         frac  = q[23:1];
         guard = q[0];
         stk   = sticky;
         exp_n = exp_in - 10'sd1;
      end
      {carry, frac_r} = {1'b0, frac} + {23'd0, guard & (stk | frac[0])};
      exp_r = carry ? exp_n + 10'sd1 : exp_n;

      if (exp_r >= 10'sd255) begin
         result = {sign, POS_INF[30:0]};
      end else if (exp_r <= 10'sd0) begin
         result = {sign, 31'd0};
      end else begin
         result = {sign, exp_r[7:0], frac_r};
      end

`ifdef FDIV_FLOAT_STATUS_EN
      flags = '0;
      if (exp_r >= 10'sd255) begin
         flags[FLAG_OVERFLOW] = 1'b1;
         flags[FLAG_INEXACT]  = 1'b1;
      end else if (exp_r <= 10'sd0) begin
         flags[FLAG_UNDERFLOW] = 1'b1;
         flags[FLAG_INEXACT]   = 1'b1;
      end else begin
         flags[FLAG_INEXACT] = guard | stk;
      end
`endif
   end
endmodule

// File: rtl/fdiv_float.sv
// rtl/fdiv_float.sv - iterative radix-2 restoring single-precision divider, one op in flight
// Optional status flags port enabled by FDIV_FLOAT_STATUS_EN.
module fdiv_float
   import fdiv_float_pkg::*;
#(
   parameter logic [31:0] P_QNAN = 32'h7FC0_0000
)
(
   input  logic         iCLOCK,
   input  logic         iRESET,
   input  logic         iRESET_SYNC,
   fdiv_float_if.slave  bus
);
   state_t                  state_q, state_d;
   logic [4:0]              count_q, count_d;
   logic [24:0]             rem_q, rem_d;
   logic [23:0]             mb_q, mb_d;
   logic [QBITS-1:0]        quo_q, quo_d;
   logic signed [EXP_W-1:0] exp_q, exp_d;
   logic                    sign_q, sign_d;
   logic [31:0]             data_q, data_d;
   logic                    valid_q, valid_d;

   logic [7:0]  ea, eb;
   logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, is_special;
   logic [31:0] special_res;
   logic [31:0] norm_res;
   logic [25:0] rem_diff;
   logic [24:0] rem_sel;
   logic        rem_ge;

`ifdef FDIV_FLOAT_STATUS_EN
   logic [FLAGS_W-1:0] flags_q, flags_d, special_flags, norm_flags;
`endif

   assign ea     = bus.iDATA_A[30:23];
   assign eb     = bus.iDATA_B[30:23];
   assign a_zero = (ea == 8'd0);
   assign b_zero = (eb == 8'd0);
   assign a_inf  = (ea == 8'hFF) && (bus.iDATA_A[22:0] == 23'd0);
   assign b_inf  = (eb == 8'hFF) && (bus.iDATA_B[22:0] == 23'd0);
   assign a_nan  = (ea == 8'hFF) && (bus.iDATA_A[22:0] != 23'd0);
   assign b_nan  = (eb == 8'hFF) && (bus.iDATA_B[22:0] != 23'd0);
   assign is_special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

   always_comb begin
      special_res = {bus.iDATA_A[31] ^ bus.iDATA_B[31], 31'd0};
`ifdef FDIV_FLOAT_STATUS_EN
      special_flags = '0;
`endif
      if (a_nan || b_nan) begin
         special_res = P_QNAN;
      end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
         special_res = P_QNAN;
`ifdef FDIV_FLOAT_STATUS_EN
         special_flags[FLAG_INVALID] = 1'b1;
`endif
      end else if (a_inf || b_zero) begin
         special_res[30:0] = POS_INF[30:0];
`ifdef FDIV_FLOAT_STATUS_EN
         special_flags[FLAG_DIVBYZERO] = !a_inf;
`endif
      end
   end

   fdiv_float_norm_round u_norm_round (
      .sign   (sign_q),
      .q      (quo_q),
      .sticky (rem_q != 25'd0),
      .exp_in (exp_q),
      .result (norm_res)
`ifdef FDIV_FLOAT_STATUS_EN
      ,
      .flags  (norm_flags)
`endif
   );

   // Remainder stays below 2*mb, so 25 bits suffice; rem_diff[25] is the borrow.
   assign rem_diff = {1'b0, rem_q} - {2'b00, mb_q};
   assign rem_ge   = ~rem_diff[25];
   assign rem_sel  = rem_ge ? rem_diff[24:0] : rem_q;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      rem_d   = rem_q;
      mb_d    = mb_q;
      quo_d   = quo_q;
      exp_d   = exp_q;
      sign_d  = sign_q;
      data_d  = data_q;
      valid_d = valid_q;
`ifdef FDIV_FLOAT_STATUS_EN
      flags_d = flags_q;
`endif
      case (state_q)
         IDLE: if (bus.iDATA_REQ) begin
            sign_d = bus.iDATA_A[31] ^ bus.iDATA_B[31];
            if (is_special) begin
               data_d  = special_res;
               valid_d = 1'b1;
               state_d = OUT;
`ifdef FDIV_FLOAT_STATUS_EN
               flags_d = special_flags;
`endif
            end else begin
               count_d = 5'd0;
               rem_d   = {2'b01, bus.iDATA_A[22:0]};
               mb_d    = {1'b1, bus.iDATA_B[22:0]};
               quo_d   = '0;
               exp_d   = EXP_W'(ea) - EXP_W'(eb) + EXP_W'(BIAS);
               state_d = DIV;
            end
         end
         DIV: begin
            quo_d = {quo_q[QBITS-2:0], rem_ge};
            rem_d = rem_sel << 1;
            if (count_q == 5'(QBITS - 1)) begin
               state_d = NORM;
            end else begin
               count_d = count_q + 5'd1;
            end
         end
         NORM: begin
            data_d  = norm_res;
            valid_d = 1'b1;
            state_d = OUT;
`ifdef FDIV_FLOAT_STATUS_EN
            flags_d = norm_flags;
`endif
         end
         OUT: if (!bus.iDATA_BUSY) begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (iRESET_SYNC) begin
         state_d = IDLE;
         count_d = 5'd0;
         rem_d   = '0;
         mb_d    = '0;
         quo_d   = '0;
         exp_d   = '0;
         sign_d  = 1'b0;
         data_d  = '0;
         valid_d = 1'b0;
`ifdef FDIV_FLOAT_STATUS_EN
         flags_d = '0;
`endif
      end
   end

   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         state_q <= IDLE;
         count_q <= 5'd0;
         rem_q   <= '0;
         mb_q    <= '0;
         quo_q   <= '0;
         exp_q   <= '0;
         sign_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
`ifdef FDIV_FLOAT_STATUS_EN
         flags_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         rem_q   <= rem_d;
         mb_q    <= mb_d;
         quo_q   <= quo_d;
         exp_q   <= exp_d;
         sign_q  <= sign_d;
         data_q  <= data_d;
         valid_q <= valid_d;
`ifdef FDIV_FLOAT_STATUS_EN
         flags_q <= flags_d;
`endif
      end
   end

   assign bus.oDATA_BUSY  = (state_q != IDLE);
   assign bus.oDATA_VALID = valid_q;
   assign bus.oDATA       = data_q;
`ifdef FDIV_FLOAT_STATUS_EN
   assign bus.oFLAGS      = flags_q;
`endif
endmodule

// File: tb/tb_fdiv_float.sv
// tb/tb_fdiv_float.sv - randomized self-checking bench for fdiv_float; flags checked under FDIV_FLOAT_STATUS_EN
module tb_fdiv_float;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;
   localparam logic [31:0] INF  = 32'h7F80_0000;

   logic clk = 1'b0;
   logic rst;
   logic rst_sync;
   int   checks = 0;
   int   errors = 0;

   fdiv_float_if bus();

   fdiv_float #(.P_QNAN(QNAN)) dut (
      .iCLOCK      (clk),
      .iRESET      (rst),
      .iRESET_SYNC (rst_sync),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // Reference: exact integer quotient of the real mantissas, then IEEE RNE with flush-to-zero.
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           output logic [4:0] fl, output bit special);
      logic        s;
      int          ea, eb, e, sh;
      logic [63:0] ma, mb, num, q, r, mant, rest;
      bit          a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, g, st;
      s      = a[31] ^ b[31];
      ea     = int'(a[30:23]);
      eb     = int'(b[30:23]);
      a_zero = (ea == 0);
      b_zero = (eb == 0);
      a_inf  = (ea == 255) && (a[22:0] == 23'd0);
      b_inf  = (eb == 255) && (b[22:0] == 23'd0);
      a_nan  = (ea == 255) && (a[22:0] != 23'd0);
      b_nan  = (eb == 255) && (b[22:0] != 23'd0);
      fl      = 5'b00000;
      special = 1'b1;
      if (a_nan || b_nan) return QNAN;
      if ((a_zero && b_zero) || (a_inf && b_inf)) begin fl = 5'b10000; return QNAN; end
      if (a_inf) return {s, INF[30:0]};
      if (b_zero) begin fl = 5'b01000; return {s, INF[30:0]}; end
      if (a_zero || b_inf) return {s, 31'd0};
      special = 1'b0;
      ma  = 64'(a[22:0]) + (64'd1 << 23);
      mb  = 64'(b[22:0]) + (64'd1 << 23);
      num = ma << 25;
      q   = num / mb;
      r   = num % mb;
      e   = ea - eb + 127;
      if (q >= (64'd1 << 25)) sh = 2;
      else begin sh = 1; e = e - 1; end
      mant = q >> sh;
      rest = q & ((64'd1 << sh) - 64'd1);
      g    = ((rest >> (sh - 1)) & 64'd1) != 64'd0;
      st   = (r != 64'd0) || ((rest & ((64'd1 << (sh - 1)) - 64'd1)) != 64'd0);
      if (g && (st || mant[0])) mant = mant + 64'd1;
      if (mant == (64'd1 << 24)) begin mant = mant >> 1; e = e + 1; end
      if (e >= 255) begin fl = 5'b00101; return {s, INF[30:0]}; end
      if (e <= 0) begin fl = 5'b00011; return {s, 31'd0}; end
      fl = {4'b0000, g | st};
      return {s, e[7:0], mant[22:0]};
   endfunction

   function automatic logic [31:0] rand_operand();
      logic [31:0] v;
      logic [31:0] sp [6];
      sp[0] = 32'h0000_0000; sp[1] = 32'h8000_0000; sp[2] = 32'h7F80_0000;
      sp[3] = 32'hFF80_0000; sp[4] = 32'h7FC0_0000; sp[5] = 32'h0012_3456;
      v = $urandom;
      case ($urandom_range(0, 7))
         0:       v = sp[$urandom_range(0, 5)];
         1:       ;
         default: v[30:23] = 8'($urandom_range(64, 190));
      endcase
      return v;
   endfunction

   // Issues one request, scrambles operands after accept, waits for valid and lets it transfer.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic [4:0] fl, output int lat,
                         output logic busy_acc, output logic idle_after);
      int n = 0;
      while (bus.oDATA_BUSY && n < 100) begin @(negedge clk); n++; end
      bus.iDATA_REQ = 1'b1;
      bus.iDATA_A   = a;
      bus.iDATA_B   = b;
      @(negedge clk);
      bus.iDATA_REQ = 1'b0;
      bus.iDATA_A   = $urandom;
      bus.iDATA_B   = $urandom;
      busy_acc      = bus.oDATA_BUSY;
      lat = 0;
      while (!bus.oDATA_VALID && lat < 100) begin @(negedge clk); lat++; end
      res = bus.oDATA;
`ifdef FDIV_FLOAT_STATUS_EN
      fl = bus.oFLAGS;
`else
      fl = 5'b00000;
`endif
      @(negedge clk);
      idle_after = !bus.oDATA_VALID && !bus.oDATA_BUSY;
   endtask

   task automatic test_reset();
      rst = 1'b1; rst_sync = 1'b0;
      bus.iDATA_REQ = 1'b0; bus.iDATA_A = '0; bus.iDATA_B = '0; bus.iDATA_BUSY = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.oDATA_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.oDATA_VALID); end
      checks++; if (bus.oDATA_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.oDATA_BUSY); end
      checks++; if (bus.oDATA !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", bus.oDATA); end
`ifdef FDIV_FLOAT_STATUS_EN
      checks++; if (bus.oFLAGS !== 5'd0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", bus.oFLAGS); end
`endif
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [31:0] ta [9];
      logic [31:0] tb_ [9];
      logic [31:0] te [9];
      logic [4:0]  tf [9];
      int          tl [9];
      logic [31:0] res;
      logic [4:0]  fl;
      int          lat;
      logic        busy_acc, idle_after;
      ta = '{32'h40C00000, 32'h3F800000, 32'hC0C00000, 32'h3F800000, 32'h00000000,
             32'h7FC00001, 32'h80000000, 32'h7F7FFFFF, 32'h00800000};
      tb_ = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h00000000, 32'h00000000,
              32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40000000};
      te = '{32'h40400000, 32'h3EAAAAAB, 32'hC0400000, 32'h7F800000, 32'h7FC00000,
             32'h7FC00000, 32'h80000000, 32'h7F800000, 32'h00000000};
      tf = '{5'b00000, 5'b00001, 5'b00000, 5'b01000, 5'b10000,
             5'b00000, 5'b00000, 5'b00101, 5'b00011};
      tl = '{27, 27, 27, 0, 0, 0, 0, 27, 27};
      for (int i = 0; i < 9; i++) begin
         run_op(ta[i], tb_[i], res, fl, lat, busy_acc, idle_after);
         checks++; if (res !== te[i]) begin errors++; $display("FAIL directed_%0d_result: got %h expected %h", i, res, te[i]); end
         checks++; if (lat !== tl[i]) begin errors++; $display("FAIL directed_%0d_latency: got %0d expected %0d", i, lat, tl[i]); end
         checks++; if (busy_acc !== 1'b1) begin errors++; $display("FAIL directed_%0d_busy_after_accept: got %b expected 1", i, busy_acc); end
         checks++; if (idle_after !== 1'b1) begin errors++; $display("FAIL directed_%0d_idle_after_transfer: got %b expected 1", i, idle_after); end
`ifdef FDIV_FLOAT_STATUS_EN
         checks++; if (fl !== tf[i]) begin errors++; $display("FAIL directed_%0d_flags: got %b expected %b", i, fl, tf[i]); end
`else
         if (fl !== 5'd0 && tf[i] === 5'd0) $display("note: flags unexpectedly nonzero");
`endif
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, exp_res, res;
      logic [4:0]  exp_fl, fl;
      bit          special;
      int          lat;
      logic        busy_acc, idle_after;
      for (int i = 0; i < 150; i++) begin
         a = rand_operand();
         b = rand_operand();
         exp_res = ref_div(a, b, exp_fl, special);
         run_op(a, b, res, fl, lat, busy_acc, idle_after);
         checks++; if (res !== exp_res) begin errors++; $display("FAIL random_result %h/%h: got %h expected %h", a, b, res, exp_res); end
         checks++; if (lat !== (special ? 0 : 27)) begin errors++; $display("FAIL random_latency %h/%h: got %0d expected %0d", a, b, lat, special ? 0 : 27); end
         checks++; if (idle_after !== 1'b1) begin errors++; $display("FAIL random_idle_after %h/%h: got %b expected 1", a, b, idle_after); end
`ifdef FDIV_FLOAT_STATUS_EN
         checks++; if (fl !== exp_fl) begin errors++; $display("FAIL random_flags %h/%h: got %b expected %b", a, b, fl, exp_fl); end
`endif
      end
   endtask

   task automatic test_backpressure();
      int n = 0;
      int seen = 0;
      bus.iDATA_BUSY = 1'b1;
      bus.iDATA_REQ  = 1'b1;
      bus.iDATA_A    = 32'h3F800000;
      bus.iDATA_B    = 32'h40400000;
      @(negedge clk);
      bus.iDATA_REQ = 1'b0;
      while (!bus.oDATA_VALID && n < 100) begin @(negedge clk); n++; end
      checks++; if (bus.oDATA_VALID !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout: got %b expected 1", bus.oDATA_VALID); end
      for (int i = 0; i < 5; i++) begin
         bus.iDATA_REQ = 1'b1;
         bus.iDATA_A   = $urandom;
         bus.iDATA_B   = 32'h3F800000;
         @(negedge clk);
         checks++; if (bus.oDATA_VALID !== 1'b1) begin errors++; $display("FAIL bp_hold_valid_%0d: got %b expected 1", i, bus.oDATA_VALID); end
         checks++; if (bus.oDATA !== 32'h3EAAAAAB) begin errors++; $display("FAIL bp_hold_data_%0d: got %h expected 3eaaaaab", i, bus.oDATA); end
         checks++; if (bus.oDATA_BUSY !== 1'b1) begin errors++; $display("FAIL bp_hold_busy_%0d: got %b expected 1", i, bus.oDATA_BUSY); end
      end
      bus.iDATA_BUSY = 1'b0;
      bus.iDATA_REQ  = 1'b0;
      @(negedge clk);
      checks++; if (bus.oDATA_VALID !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", bus.oDATA_VALID); end
      checks++; if (bus.oDATA_BUSY !== 1'b0) begin errors++; $display("FAIL bp_release_busy: got %b expected 0", bus.oDATA_BUSY); end
      repeat (40) begin @(negedge clk); if (bus.oDATA_VALID) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL bp_ignored_request: got %0d valid cycles expected 0", seen); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res;
      logic [4:0]  fl;
      int          lat, seen;
      logic        busy_acc, idle_after;
      // Asynchronous reset at DIV count 10.
      bus.iDATA_REQ = 1'b1; bus.iDATA_A = 32'h40C00000; bus.iDATA_B = 32'h40000000;
      @(negedge clk);
      bus.iDATA_REQ = 1'b0;
      repeat (10) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checks++; if (bus.oDATA_BUSY !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", bus.oDATA_BUSY); end
      checks++; if (bus.oDATA_VALID !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", bus.oDATA_VALID); end
      checks++; if (bus.oDATA !== 32'd0) begin errors++; $display("FAIL arst_data: got %h expected 00000000", bus.oDATA); end
      rst = 1'b0;
      seen = 0;
      repeat (40) begin @(negedge clk); if (bus.oDATA_VALID) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL arst_no_valid: got %0d valid cycles expected 0", seen); end

      // Synchronous clear at DIV count 10; leave nonzero data behind first.
      run_op(32'h40C00000, 32'h40000000, res, fl, lat, busy_acc, idle_after);
      checks++; if (res !== 32'h40400000) begin errors++; $display("FAIL recover_after_arst: got %h expected 40400000", res); end
      bus.iDATA_REQ = 1'b1; bus.iDATA_A = 32'h3F800000; bus.iDATA_B = 32'h40400000;
      @(negedge clk);
      bus.iDATA_REQ = 1'b0;
      repeat (10) @(negedge clk);
      rst_sync = 1'b1;
      #1;
      checks++; if (bus.oDATA_BUSY !== 1'b1) begin errors++; $display("FAIL srst_before_edge_busy: got %b expected 1", bus.oDATA_BUSY); end
      @(negedge clk);
      checks++; if (bus.oDATA_BUSY !== 1'b0) begin errors++; $display("FAIL srst_busy: got %b expected 0", bus.oDATA_BUSY); end
      checks++; if (bus.oDATA_VALID !== 1'b0) begin errors++; $display("FAIL srst_valid: got %b expected 0", bus.oDATA_VALID); end
      checks++; if (bus.oDATA !== 32'd0) begin errors++; $display("FAIL srst_data: got %h expected 00000000", bus.oDATA); end
      rst_sync = 1'b0;
      seen = 0;
      repeat (40) begin @(negedge clk); if (bus.oDATA_VALID) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL srst_no_valid: got %0d valid cycles expected 0", seen); end
      run_op(32'hC0C00000, 32'h40000000, res, fl, lat, busy_acc, idle_after);
      checks++; if (res !== 32'hC0400000) begin errors++; $display("FAIL recover_after_srst: got %h expected c0400000", res); end
      checks++; if (lat !== 27) begin errors++; $display("FAIL recover_after_srst_latency: got %0d expected 27", lat); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
